// File: rtl/arc4_sched.sv
// ARC4 top-level sequencer: runs init -> ksa -> prga and muxes the shared S-memory port.
// Optional feature macro: ARC4_SCHED_PRGA_EN (defined = run the prga phase after ksa).
module arc4_sched (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    output logic       rdy,
    output logic [1:0] phase,
    output logic       init_en,
    input  logic       init_rdy,
    input  logic [7:0] init_addr,
    input  logic [7:0] init_wrdata,
    input  logic       init_wren,
    output logic       ksa_en,
    input  logic       ksa_rdy,
    input  logic [7:0] ksa_addr,
    input  logic [7:0] ksa_wrdata,
    input  logic       ksa_wren,
    output logic       prga_en,
    input  logic       prga_rdy,
    input  logic [7:0] prga_addr,
    input  logic [7:0] prga_wrdata,
    input  logic       prga_wren,
    output logic [7:0] s_addr,
    output logic [7:0] s_wrdata,
    output logic       s_wren,
    input  logic [7:0] s_rddata
);

    typedef enum logic [2:0] {
        IDLE,
        INIT_GO,
        INIT_RUN,
        KSA_GO,
        KSA_RUN,
        PRGA_GO,
        PRGA_RUN
    } state_t;

    state_t state_q, state_d;

    // Read data goes straight to the sub-blocks; without prga its request port is ignored.
    logic unused_inputs;
`ifdef ARC4_SCHED_PRGA_EN
    assign unused_inputs = ^s_rddata;
`else
    assign unused_inputs = ^{s_rddata, prga_rdy, prga_addr, prga_wrdata, prga_wren};
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        rdy      = 1'b0;
        phase    = 2'd0;
        init_en  = 1'b0;
        ksa_en   = 1'b0;
        prga_en  = 1'b0;
        s_addr   = 8'd0;
        s_wrdata = 8'd0;
        s_wren   = 1'b0;
        case (state_q)
            IDLE: begin
                rdy = 1'b1;
                if (en) state_d = INIT_GO;
            end
            INIT_GO, INIT_RUN: begin
                phase    = 2'd1;
                init_en  = (state_q == INIT_GO);
                s_addr   = init_addr;
                s_wrdata = init_wrdata;
                s_wren   = init_wren;
                if (init_rdy) state_d = (state_q == INIT_GO) ? INIT_RUN : KSA_GO;
            end
            KSA_GO, KSA_RUN: begin
                phase    = 2'd2;
                ksa_en   = (state_q == KSA_GO);
                s_addr   = ksa_addr;
                s_wrdata = ksa_wrdata;
                s_wren   = ksa_wren;
                if (ksa_rdy) begin
`ifdef ARC4_SCHED_PRGA_EN
                    state_d = (state_q == KSA_GO) ? KSA_RUN : PRGA_GO;
`else
                    state_d = (state_q == KSA_GO) ? KSA_RUN : IDLE;
`endif
                end
            end
`ifdef ARC4_SCHED_PRGA_EN
            PRGA_GO, PRGA_RUN: begin
                phase    = 2'd3;
                prga_en  = (state_q == PRGA_GO);
                s_addr   = prga_addr;
                s_wrdata = prga_wrdata;
                s_wren   = prga_wren;
                if (prga_rdy) state_d = (state_q == PRGA_GO) ? PRGA_RUN : IDLE;
            end
`endif
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_arc4_sched.sv
// Bench for arc4_sched: behavioural sub-block and S-memory models, a phase/go-level
// reference for the sequencer, per-cycle comparison, and hand-computed run totals.
module tb_arc4_sched;

    localparam int INIT_LEN = 256;   // init writes S[k]=k, k=0..255
    localparam int KSA_LEN  = 120;   // ksa writes S[k]=k+0xA0, k=0..119
    localparam int PRGA_LEN = 10;    // prga writes S[200+k]=k^0x5A
    // Busy cycles per phase = (LEN-1 cycles with sub-block rdy=0) + GO + completion.
`ifdef ARC4_SCHED_PRGA_EN
    localparam int LAST_PH   = 3;
    localparam int EXP_BUSY  = 389;   // 255+119+9 + 6
    localparam int EXP_SEQ   = 'h1230;
    localparam int EXP_PRGAN = 1;
`else
    localparam int LAST_PH   = 2;
    localparam int EXP_BUSY  = 378;   // 255+119 + 4
    localparam int EXP_SEQ   = 'h120;
    localparam int EXP_PRGAN = 0;
`endif

    logic       clk, rst_n, en, rdy;
    logic [1:0] phase;
    logic       init_en, init_rdy, init_wren, ksa_en, ksa_rdy, ksa_wren, prga_en, prga_rdy, prga_wren;
    logic [7:0] init_addr, init_wrdata, ksa_addr, ksa_wrdata, prga_addr, prga_wrdata;
    logic [7:0] s_addr, s_wrdata, s_rddata;
    logic       s_wren;
    logic       init_hold, init_inj;

    int checks, errors;
    int busy_cnt, initen_cnt, prgaen_cnt, seq, last_ph;

    arc4_sched dut (
        .clk(clk), .rst_n(rst_n), .en(en), .rdy(rdy), .phase(phase),
        .init_en(init_en), .init_rdy(init_rdy), .init_addr(init_addr),
        .init_wrdata(init_wrdata), .init_wren(init_wren),
        .ksa_en(ksa_en), .ksa_rdy(ksa_rdy), .ksa_addr(ksa_addr),
        .ksa_wrdata(ksa_wrdata), .ksa_wren(ksa_wren),
        .prga_en(prga_en), .prga_rdy(prga_rdy), .prga_addr(prga_addr),
        .prga_wrdata(prga_wrdata), .prga_wren(prga_wren),
        .s_addr(s_addr), .s_wrdata(s_wrdata), .s_wren(s_wren), .s_rddata(s_rddata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // S memory
    logic [7:0] mem [256];
    always @(posedge clk) if (s_wren) mem[s_addr] <= s_wrdata;
    assign s_rddata = mem[s_addr];

    // Sub-block models: idle with rdy=1; after the handshake run LEN cycles, rdy back up in the last one.
    logic i_busy, k_busy, p_busy;
    int   i_cnt, k_cnt, p_cnt;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            i_busy <= 1'b0; i_cnt <= 0;
        end else if (!i_busy) begin
            if (init_en && init_rdy) begin i_busy <= 1'b1; i_cnt <= 0; end
        end else if (i_cnt == INIT_LEN - 1) i_busy <= 1'b0;
        else i_cnt <= i_cnt + 1;
    end
    assign init_rdy    = i_busy ? (i_cnt == INIT_LEN - 1) : !init_hold;
    assign init_addr   = init_inj ? 8'h55 : i_cnt[7:0];
    assign init_wrdata = init_inj ? 8'hEE : i_cnt[7:0];
    assign init_wren   = i_busy | init_inj;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            k_busy <= 1'b0; k_cnt <= 0;
        end else if (!k_busy) begin
            if (ksa_en && ksa_rdy) begin k_busy <= 1'b1; k_cnt <= 0; end
        end else if (k_cnt == KSA_LEN - 1) k_busy <= 1'b0;
        else k_cnt <= k_cnt + 1;
    end
    assign ksa_rdy    = k_busy ? (k_cnt == KSA_LEN - 1) : 1'b1;
    assign ksa_addr   = k_cnt[7:0];
    assign ksa_wrdata = 8'(k_cnt + 'hA0);
    assign ksa_wren   = k_busy;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p_busy <= 1'b0; p_cnt <= 0;
        end else if (!p_busy) begin
            if (prga_en && prga_rdy) begin p_busy <= 1'b1; p_cnt <= 0; end
        end else if (p_cnt == PRGA_LEN - 1) p_busy <= 1'b0;
        else p_cnt <= p_cnt + 1;
    end
    assign prga_rdy    = p_busy ? (p_cnt == PRGA_LEN - 1) : 1'b1;
    assign prga_addr   = 8'(200 + p_cnt);
    assign prga_wrdata = p_cnt[7:0] ^ 8'h5A;
    assign prga_wren   = p_busy;

    // Reference: which phase owns the port (0 = idle) and whether its start pulse is still pending.
    int m_owner;
    bit m_go;
    logic [2:0] sub_rdy;
    assign sub_rdy = {prga_rdy, ksa_rdy, init_rdy};

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_owner <= 0; m_go <= 1'b0;
        end else if (m_owner == 0) begin
            if (en) begin m_owner <= 1; m_go <= 1'b1; end
        end else if (sub_rdy[m_owner-1]) begin
            if (m_go) m_go <= 1'b0;
            else if (m_owner == LAST_PH) m_owner <= 0;
            else begin m_owner <= m_owner + 1; m_go <= 1'b1; end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic compare();
        logic [7:0] ea, ed;
        logic       ew;
        ea = 8'd0; ed = 8'd0; ew = 1'b0;
        case (m_owner)
            1: begin ea = init_addr; ed = init_wrdata; ew = init_wren; end
            2: begin ea = ksa_addr;  ed = ksa_wrdata;  ew = ksa_wren;  end
            3: begin ea = prga_addr; ed = prga_wrdata; ew = prga_wren; end
            default: ;
        endcase
        chk("rdy", rdy, m_owner == 0);
        chk("phase", phase, m_owner);
        chk("init_en", init_en, m_go && m_owner == 1);
        chk("ksa_en", ksa_en, m_go && m_owner == 2);
        chk("prga_en", prga_en, m_go && m_owner == 3);
        chk("s_addr", s_addr, ea);
        chk("s_wrdata", s_wrdata, ed);
        chk("s_wren", s_wren, ew);
        if (!rdy) busy_cnt++;
        if (init_en) initen_cnt++;
        if (prga_en) prgaen_cnt++;
        if (int'(phase) != last_ph) begin seq = (seq << 4) | int'(phase); last_ph = int'(phase); end
    endtask

    // Compare mid-cycle, then advance to just after the next rising edge.
    task automatic tick();
        @(negedge clk);
        compare();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] exp_mem(input int k);
        logic [7:0] v;
        v = 8'(k);
        if (k < KSA_LEN) v = 8'(k + 'hA0);
`ifdef ARC4_SCHED_PRGA_EN
        if (k >= 200 && k < 200 + PRGA_LEN) v = 8'(k - 200) ^ 8'h5A;
`endif
        return v;
    endfunction

    task automatic check_mem(input string nm);
        int bad;
        bad = 0;
        for (int k = 0; k < 256; k++) if (mem[k] !== exp_mem(k)) bad++;
        chk(nm, bad, 0);
    endtask

    task automatic do_run(input int hold, input bit inj, input string nm);
        int n;
        busy_cnt = 0; initen_cnt = 0; prgaen_cnt = 0; seq = 0; last_ph = 0;
        en = 1'b1;
        init_hold = (hold > 0);
        tick();
        en = 1'b0;
        if (hold > 0) begin
            repeat (hold) tick();
            init_hold = 1'b0;
        end
        n = 0;
        while (!rdy && n < 3000) begin
            if (inj) begin
                en       = (phase == 2'd2);
                init_inj = (phase == 2'd2);
            end
            tick();
            n++;
        end
        en = 1'b0;
        init_inj = 1'b0;
        chk({nm, " timeout"}, n < 3000, 1);
        repeat (3) tick();
        chk({nm, " idle_after"}, rdy, 1);
        chk({nm, " busy_cycles"}, busy_cnt, EXP_BUSY + hold);
        chk({nm, " init_en_cycles"}, initen_cnt, 1 + hold);
        chk({nm, " prga_en_cycles"}, prgaen_cnt, EXP_PRGAN);
        chk({nm, " phase_seq"}, seq, EXP_SEQ);
        check_mem({nm, " mem"});
        $display("run %s: busy=%0d init_en=%0d seq=%0h", nm, busy_cnt, initen_cnt, seq);
    endtask

    initial begin
        int n;
        checks = 0; errors = 0;
        busy_cnt = 0; initen_cnt = 0; prgaen_cnt = 0; seq = 0; last_ph = 0;
        rst_n = 1'b0; en = 1'b0; init_hold = 1'b0; init_inj = 1'b0;
        #1;
        chk("reset rdy", rdy, 1);
        chk("reset phase", phase, 0);
        chk("reset en_all", {init_en, ksa_en, prga_en}, 0);
        chk("reset s_port", {s_addr, s_wrdata, s_wren}, 0);
        repeat (2) tick();
        rst_n = 1'b1;
        repeat (3) tick();
        chk("idle rdy", rdy, 1);
        chk("idle phase", phase, 0);
        chk("idle en_all", {init_en, ksa_en, prga_en}, 0);
        chk("idle s_wren", s_wren, 0);
        chk("idle s_addr", s_addr, 0);

        do_run(0, 1'b0, "basic");
        do_run(4, 1'b0, "init_hold4");
        do_run(0, 1'b1, "en_inject");

        // Reset while ksa is at address 100.
        en = 1'b1;
        tick();
        en = 1'b0;
        n = 0;
        while (!(phase == 2'd2 && ksa_addr == 8'd100) && n < 2000) begin
            tick();
            n++;
        end
        chk("midksa reached", n < 2000, 1);
        rst_n = 1'b0;
        #1;
        chk("midksa rdy", rdy, 1);
        chk("midksa phase", phase, 0);
        chk("midksa ksa_en", ksa_en, 0);
        chk("midksa s_wren", s_wren, 0);
        tick();
        rst_n = 1'b1;
        tick();
        do_run(0, 1'b0, "after_reset");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
